// File: rtl/turf_eth_pkg.sv
// turf_eth_pkg: shared UDP stream widths and the fragment arbiter state encoding.
package turf_eth_pkg;
   localparam int UDP_HDR_W  = 64;
   localparam int UDP_DATA_W = 64;
   localparam int UDP_KEEP_W = 8;
   localparam int UDP_PORT_W = 16;
   typedef enum logic [1:0] {ARB_IDLE, ARB_HDR, ARB_PAYLOAD} arb_state_t;
endpackage

// File: rtl/turf_rr_pick.sv
// turf_rr_pick: combinational rotating-priority pick of the first requester at or above ptr.
module turf_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          vld
);
   logic [2*N-1:0] dbl;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;
   // rotate so ptr lands at bit 0, then the lowest set bit is the winner
   always_comb begin
      dbl = {req, req} >> ptr;
      off = '0;
      for (int i = N - 1; i >= 0; i--)
         if (dbl[i]) off = IW'(i);
      sum = {1'b0, ptr} + {1'b0, off};
      idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      vld = |req;
      gnt = vld ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/turf_fragment_arb.sv
// turf_fragment_arb: round-robin arbiter granting whole UDP fragments (header + payload) to NSRC sources.
// Define TURF_FRAGMENT_ARB_STATS_EN to build the per-source completed-fragment counters.
module turf_fragment_arb
   import turf_eth_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [UDP_HDR_W*NSRC-1:0]  s_hdr_tdata,
   input  logic [UDP_PORT_W*NSRC-1:0] s_hdr_tuser,
   input  logic [NSRC-1:0]            s_hdr_tvalid,
   output logic [NSRC-1:0]            s_hdr_tready,
   input  logic [UDP_DATA_W*NSRC-1:0] s_payload_tdata,
   input  logic [UDP_KEEP_W*NSRC-1:0] s_payload_tkeep,
   input  logic [NSRC-1:0]            s_payload_tuser,
   input  logic [NSRC-1:0]            s_payload_tlast,
   input  logic [NSRC-1:0]            s_payload_tvalid,
   output logic [NSRC-1:0]            s_payload_tready,
   output logic [UDP_HDR_W-1:0]       m_hdr_tdata,
   output logic [UDP_PORT_W-1:0]      m_hdr_tuser,
   output logic                       m_hdr_tvalid,
   input  logic                       m_hdr_tready,
   output logic [UDP_DATA_W-1:0]      m_payload_tdata,
   output logic [UDP_KEEP_W-1:0]      m_payload_tkeep,
   output logic                       m_payload_tuser,
   output logic                       m_payload_tlast,
   output logic                       m_payload_tvalid,
   input  logic                       m_payload_tready,
   output logic [NSRC-1:0]            grant_o,
   output logic [32*NSRC-1:0]         frag_count_o
);
   localparam int IW = $clog2(NSRC);

   arb_state_t      st;
   logic [NSRC-1:0] grant, pick_gnt;
   logic [IW-1:0]   gidx, pick_idx, rr_ptr;
   logic            pick_vld, in_hdr, in_pay, hdr_hs, pay_end;

   turf_rr_pick #(.N(NSRC)) u_pick (
      .req (s_hdr_tvalid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .vld (pick_vld)
   );

   assign in_hdr = st == ARB_HDR;
   assign in_pay = st == ARB_PAYLOAD;
   assign grant_o = grant;

   // outputs are forced to zero outside their phase so reset clears them instantly
   assign m_hdr_tvalid     = in_hdr & s_hdr_tvalid[gidx];
   assign m_hdr_tdata      = in_hdr ? s_hdr_tdata[gidx*UDP_HDR_W +: UDP_HDR_W] : '0;
   assign m_hdr_tuser      = in_hdr ? s_hdr_tuser[gidx*UDP_PORT_W +: UDP_PORT_W] : '0;
   assign s_hdr_tready     = (in_hdr && m_hdr_tready) ? grant : '0;
   assign m_payload_tvalid = in_pay & s_payload_tvalid[gidx];
   assign m_payload_tdata  = in_pay ? s_payload_tdata[gidx*UDP_DATA_W +: UDP_DATA_W] : '0;
   assign m_payload_tkeep  = in_pay ? s_payload_tkeep[gidx*UDP_KEEP_W +: UDP_KEEP_W] : '0;
   assign m_payload_tuser  = in_pay & s_payload_tuser[gidx];
   assign m_payload_tlast  = in_pay & s_payload_tlast[gidx];
   assign s_payload_tready = (in_pay && m_payload_tready) ? grant : '0;

   assign hdr_hs  = m_hdr_tvalid & m_hdr_tready;
   assign pay_end = m_payload_tvalid & m_payload_tready & m_payload_tlast;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         st     <= ARB_IDLE;
         grant  <= '0;
         gidx   <= '0;
         rr_ptr <= '0;
      end else begin
         case (st)
            ARB_IDLE: if (pick_vld) begin
               st    <= ARB_HDR;
               grant <= pick_gnt;
               gidx  <= pick_idx;
            end
            ARB_HDR: if (hdr_hs) st <= ARB_PAYLOAD;
            ARB_PAYLOAD: if (pay_end) begin
               st     <= ARB_IDLE;
               grant  <= '0;
               rr_ptr <= (gidx == IW'(NSRC - 1)) ? '0 : gidx + 1'b1;
            end
            default: st <= ARB_IDLE;
         endcase
      end
   end

`ifdef TURF_FRAGMENT_ARB_STATS_EN
   for (genvar k = 0; k < NSRC; k++) begin : g_cnt
      logic [31:0] cnt;
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) cnt <= '0;
         else if (pay_end && gidx == IW'(k)) cnt <= cnt + 1'b1;
      end
      assign frag_count_o[k*32 +: 32] = cnt;
   end
`else
   assign frag_count_o = '0;
`endif
endmodule

// File: doc/turf_fragment_arb.md
TURF_FRAGMENT_ARB -- requirements
Module: turf_fragment_arb

Interface
REQ-001 Parameter: NSRC, 4, number of fragment-generator sources (2..8).
REQ-002 Port: aclk  in  1  sole clock; all logic on rising edge.
REQ-003 Port: aresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: s_hdr_tdata  in  64*NSRC  per-source UDP header (63:32 IP, 31:16 port, 15:0 length); slice k = source k.
REQ-005 Port: s_hdr_tuser  in  16*NSRC  per-source UDP source port.
REQ-006 Port: s_hdr_tvalid / s_hdr_tready  in / out  NSRC each  per-source header handshake.
REQ-007 Port: s_payload_tdata  in  64*NSRC  per-source payload.
REQ-008 Port: s_payload_tkeep  in  8*NSRC  per-source byte enables.
REQ-009 Port: s_payload_tuser / s_payload_tlast  in  NSRC each  per-source user bit, end-of-fragment.
REQ-010 Port: s_payload_tvalid / s_payload_tready  in / out  NSRC each  per-source payload handshake.
REQ-011 Port: m_hdr_tdata  out  64, m_hdr_tuser  out  16, m_hdr_tvalid  out  1, m_hdr_tready  in  1  header stream to UDP core.
REQ-012 Port: m_payload_tdata  out  64, m_payload_tkeep  out  8, m_payload_tuser / m_payload_tlast / m_payload_tvalid  out  1 each, m_payload_tready  in  1  payload stream to UDP core.
REQ-013 Port: grant_o  out  NSRC  one-hot current owner; all-zero in IDLE.
REQ-014 Port: frag_count_o  out  32*NSRC  per-source completed-fragment counters.

Function
REQ-015 FSM states IDLE, HDR, PAYLOAD; arbitration unit is one whole fragment (one header plus payload through tlast).
REQ-016 IDLE: when any s_hdr_tvalid is high, the block SHALL register grant to the first requester at or above rr_ptr, wrapping modulo NSRC, and enter HDR next cycle (1-cycle arbitration latency).
REQ-017 HDR: m_hdr_* SHALL be muxed from the granted source, s_hdr_tready[g]=m_hdr_tready; handshake -> PAYLOAD.
REQ-018 PAYLOAD: m_payload_* muxed from granted source, s_payload_tready[g]=m_payload_tready; handshake with tlast=1 -> IDLE and rr_ptr <= (g+1) mod NSRC.
REQ-019 All non-granted s_hdr_tready and s_payload_tready SHALL be 0; all s_*_tready 0 in IDLE.
REQ-020 m_hdr_tvalid SHALL be 0 outside HDR; m_payload_tvalid 0 outside PAYLOAD.
REQ-021 Payload tvalid from a source before its header is accepted SHALL be ignored (no transfer).
REQ-022 Requests arriving during HDR/PAYLOAD SHALL wait; the grant is never pre-empted.
REQ-023 Single requester SHALL be served back-to-back with one IDLE cycle between fragments.
REQ-024 Back-pressure: m_*_tready low holds state and data; no beats dropped or duplicated.

Reset
REQ-025 aresetn low SHALL asynchronously force IDLE, grant_o=0, rr_ptr=0, all tvalid/tready outputs 0, frag_count_o=0.
REQ-026 Reset mid-fragment SHALL abandon the fragment; the first post-reset grant goes to the lowest-index requester.

Configuration
REQ-027 Macro TURF_FRAGMENT_ARB_STATS_EN defined: frag_count_o[k] SHALL increment by 1 on each tlast payload handshake of source k, wrapping 0xFFFFFFFF->0.
REQ-028 Macro undefined: frag_count_o SHALL be constant 0 and no counter registers exist.

Structure
REQ-029 Shared package turf_eth_pkg SHALL hold UDP_HDR_W=64, UDP_DATA_W=64, UDP_KEEP_W=8, UDP_PORT_W=16 and the arbiter state enum.
REQ-030 Rotating-priority pick SHALL be the sub-module turf_rr_pick (request vector + pointer in, one-hot grant + valid out, combinational).

Verification
REQ-031 Source 0 only, 3 fragments of 2 beats each -> 3 headers, 6 payload beats in order, grant_o=0001 each time, frag_count_o[0]=3 (stats on).
REQ-032 All 4 sources request simultaneously after reset -> grant order 0,1,2,3 with complete fragments, no interleaving.
REQ-033 Source 2 owns grant, source 1 requests mid-payload -> source 2 completes through tlast before source 1 header appears.
REQ-034 m_payload_tready toggled 50% random during a 9-beat fragment -> output data/tkeep identical to input, tlast only on beat 9.
REQ-035 aresetn pulsed low during source 3 payload beat 4 -> all outputs 0 same cycle; after release source 0 and 3 requesting -> source 0 granted first.
REQ-036 Stats off build, 5 fragments -> frag_count_o remains 0.
